// File: rtl/unit_addr_dispatcher_if.sv
// Request / FIFO-write bundle of the unit address dispatcher.
// master = request source and FIFO side, slave = the dispatcher itself.
interface unit_addr_dispatcher_if #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int OP_WIDTH    = 32,
  parameter int WIN_SHIFT   = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [W_WIDTH-1:0]     req_addr;
  logic [OP_WIDTH-1:0]    req_data;
  logic [NUM_SW_INST-1:0] full_in;
  logic [NUM_SW_INST-1:0] wr_fifo;
  logic [OP_WIDTH-1:0]    wr_data;
  logic [WIN_SHIFT-1:0]   wr_offs;
  logic                   err_unmapped;
  logic [7:0]             err_cnt;

  modport master (
    output req_valid, req_addr, req_data, full_in,
    input  req_ready, wr_fifo, wr_data, wr_offs, err_unmapped, err_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, full_in,
    output req_ready, wr_fifo, wr_data, wr_offs, err_unmapped, err_cnt
  );
endinterface

// File: rtl/unit_addr_dispatcher.sv
// Ingress stage of the unit address decoder: takes one request at a time, decodes it
// into a switch-instance window and emits a registered one-hot FIFO write strobe.
module unit_addr_dispatcher #(
  parameter int               NUM_SW_INST = 5,
  parameter int               W_WIDTH     = 8,
  parameter int               OP_WIDTH    = 32,
  parameter logic [W_WIDTH-1:0] BASE_ADDR = 8'h00,
  parameter int               WIN_SHIFT   = 4
) (
  input logic clk,
  input logic rst,
  unit_addr_dispatcher_if.slave bus
);

  localparam int IDX_W = W_WIDTH - WIN_SHIFT;

  typedef enum logic [1:0] {IDLE, DISPATCH, STALL} state_t;

  state_t state_reg, state_next;

  logic [W_WIDTH-1:0]     addr_reg;
  logic [OP_WIDTH-1:0]    data_reg;
  logic [NUM_SW_INST-1:0] wr_fifo_reg;
  logic [OP_WIDTH-1:0]    wr_data_reg;
  logic [WIN_SHIFT-1:0]   wr_offs_reg;
  logic                   err_unmapped_reg;
  logic [7:0]             err_cnt_reg;

  logic [W_WIDTH-1:0]     off;
  logic [IDX_W-1:0]       win_idx;
  logic                   hit;
  logic [NUM_SW_INST-1:0] sel_vec;
  logic                   target_full;
  logic                   ready_next;
  logic                   accept;
  logic                   issue_wr;
  logic                   issue_err;

  // Decode always works on the held address, never on the live bus.
  assign off     = addr_reg - BASE_ADDR;
  assign win_idx = off[W_WIDTH-1:WIN_SHIFT];
  assign hit     = (addr_reg >= BASE_ADDR) && (int'(win_idx) < NUM_SW_INST);

  // One-hot target select; only the selected instance's full flag matters.
  generate
    for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_sel
      assign sel_vec[gi] = hit && (int'(win_idx) == gi);
    end
  endgenerate

  assign target_full = |(sel_vec & bus.full_in);

  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    accept     = 1'b0;
    issue_wr   = 1'b0;
    issue_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        if (!hit) begin
          issue_err  = 1'b1;
          state_next = IDLE;
        end else if (target_full) begin
          state_next = STALL;
        end else begin
          issue_wr   = 1'b1;
          state_next = IDLE;
        end
      end
      STALL: begin
        if (!target_full) begin
          issue_wr   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg         <= '0;
      data_reg         <= '0;
      wr_fifo_reg      <= '0;
      wr_data_reg      <= '0;
      wr_offs_reg      <= '0;
      err_unmapped_reg <= 1'b0;
      err_cnt_reg      <= 8'h00;
    end else begin
      wr_fifo_reg      <= issue_wr ? sel_vec : '0;
      err_unmapped_reg <= issue_err;
      if (accept) begin
        addr_reg <= bus.req_addr;
        data_reg <= bus.req_data;
      end
      if (issue_wr) begin
        wr_data_reg <= data_reg;
        wr_offs_reg <= off[WIN_SHIFT-1:0];
      end
      if (issue_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // Ready is forced low for the whole reset pulse, not just after it.
  assign bus.req_ready    = ready_next && !rst;
  assign bus.wr_fifo      = wr_fifo_reg;
  assign bus.wr_data      = wr_data_reg;
  assign bus.wr_offs      = wr_offs_reg;
  assign bus.err_unmapped = err_unmapped_reg;
  assign bus.err_cnt      = err_cnt_reg;

endmodule
